addsub_pipe: RTL

Parametrised, pipelined signed adder/subtractor replacing the fixed 16-bit `addsub16` core in the datapath. Operands are two's-complement. The carry chain is split across `STAGES` register stages so wide operands close timing. A valid tag travels with each operation. The block reports signed overflow and can optionally saturate. It sits between the CIC/halfband arithmetic and the downstream scaling logic, stalled by the shared `clken` strobe.

---
 rtl/addsub_pkg.sv | 24 ++
 rtl/addsub_seg.sv | 36 +++
 rtl/addsub_pipe.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the addsub_pipe datapath: stage limit,
// saturation constants and the parameter legality check used at elaboration.
package addsub_pkg;

    localparam int ADDSUB_MAX_STAGES = 4;
    localparam int ADDSUB_MAX_WIDTH  = 64;

    // Signed saturation value for a given width, sign-extended to ADDSUB_MAX_WIDTH:
    // neg = 0 gives 2^(width-1)-1, neg = 1 gives -2^(width-1).
    function automatic logic [ADDSUB_MAX_WIDTH-1:0] addsub_sat_value(input int width, input logic neg);
        logic [ADDSUB_MAX_WIDTH-1:0] v;
        for (int i = 0; i < ADDSUB_MAX_WIDTH; i++) begin
            v[i] = (i < width - 1) ? ~neg : neg;
        end
        return v;
    endfunction

    function automatic bit addsub_cfg_ok(input int width, input int stages);
        return (width >= 4) && (width <= ADDSUB_MAX_WIDTH) &&
               (stages >= 1) && (stages <= ADDSUB_MAX_STAGES) &&
               (width % stages == 0);
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: one registered SEG-bit slice of the split carry chain.
// The carry-out is registered so the next slice adds one enabled cycle later.
module addsub_seg #(
    parameter int SEG = 8
) (
    input  logic           clock,
    input  logic           aclr,
    input  logic           clken,
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           cin_i,
    output logic [SEG-1:0] sum_o,
    output logic           cout_o
);

    logic [SEG:0]   sum_d;
    logic [SEG-1:0] sum_q;
    logic           cout_q;

    assign sum_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};

    // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (clken) begin
            sum_q  <= sum_d[SEG-1:0];
            cout_q <= sum_d[SEG];
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined signed adder/subtractor, carry chain split over STAGES slices.
// Define ADDSUB_PIPE_SAT_EN to clamp overflowing results instead of wrapping them.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             clken,
    input  logic             in_valid,
    input  logic             add_sub,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int SEG = WIDTH / STAGES;

    if (!addsub_cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("addsub_pipe: WIDTH must be >= 4 and divisible by STAGES (1..4)");
    end

    logic [WIDTH-1:0]  b_eff;
    logic [STAGES-1:0] carry;
    logic [WIDTH-1:0]  sum_raw;
    logic              a_sign_w, b_sign_w;
    logic              a_sign_q, b_sign_q;
    logic [STAGES-1:0] vld_q, vld_d;
    logic              ovf;

    assign b_eff    = add_sub ? datab : ~datab;
    assign carry[0] = ~add_sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        logic [SEG-1:0] a_seg, b_seg, sum_seg;
        logic           cout;

        if (k == 0) begin : g_direct
            assign a_seg = dataa[SEG-1:0];
            assign b_seg = b_eff[SEG-1:0];
        end else begin : g_skew
            logic [SEG-1:0] a_q [1:k];
            logic [SEG-1:0] b_q [1:k];

            // NOTE: skew storage is cleared too, so nothing from before aclr survives anywhere.
            always_ff @(posedge clock or posedge aclr) begin
                if (aclr) begin
                    for (int i = 1; i <= k; i++) begin
                        a_q[i] <= '0;
                        b_q[i] <= '0;
                    end
                end else if (clken) begin
                    a_q[1] <= dataa[k*SEG +: SEG];
                    b_q[1] <= b_eff[k*SEG +: SEG];
                    for (int i = 2; i <= k; i++) begin
                        a_q[i] <= a_q[i-1];
                        b_q[i] <= b_q[i-1];
                    end
                end
            end

            assign a_seg = a_q[k];
            assign b_seg = b_q[k];
        end

        addsub_seg #(.SEG(SEG)) u_seg (
            .clock  (clock),
            .aclr   (aclr),
            .clken  (clken),
            .a_i    (a_seg),
            .b_i    (b_seg),
            .cin_i  (carry[k]),
            .sum_o  (sum_seg),
            .cout_o (cout)
        );

        if (k == STAGES - 1) begin : g_last
            logic unused_cout;
            assign unused_cout                = cout;
            assign a_sign_w                   = a_seg[SEG-1];
            assign b_sign_w                   = b_seg[SEG-1];
            assign sum_raw[k*SEG +: SEG]      = sum_seg;
        end else begin : g_deskew
            localparam int D = STAGES - 1 - k;
            logic [SEG-1:0] s_q [1:D];

            assign carry[k+1] = cout;

            always_ff @(posedge clock or posedge aclr) begin
                if (aclr) begin
                    for (int i = 1; i <= D; i++) s_q[i] <= '0;
                end else if (clken) begin
                    s_q[1] <= sum_seg;
                    for (int i = 2; i <= D; i++) s_q[i] <= s_q[i-1];
                end
            end

            assign sum_raw[k*SEG +: SEG] = s_q[D];
        end
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = in_valid;
        for (int i = 1; i < STAGES; i++) vld_d[i] = vld_q[i-1];
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            vld_q    <= '0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
        end else if (clken) begin
            vld_q    <= vld_d;
            a_sign_q <= a_sign_w;
            b_sign_q <= b_sign_w;
        end
    end

    // Overflow and saturation decode registered state only; no input reaches an output.
    assign ovf       = (a_sign_q == b_sign_q) && (sum_raw[WIDTH-1] != a_sign_q);
    assign overflow  = ovf;
    assign out_valid = vld_q[STAGES-1];

`ifdef ADDSUB_PIPE_SAT_EN
    localparam logic [ADDSUB_MAX_WIDTH-1:0] SAT_POS_FULL = addsub_sat_value(WIDTH, 1'b0);
    localparam logic [ADDSUB_MAX_WIDTH-1:0] SAT_NEG_FULL = addsub_sat_value(WIDTH, 1'b1);
    localparam logic [WIDTH-1:0]            SAT_POS      = SAT_POS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]            SAT_NEG      = SAT_NEG_FULL[WIDTH-1:0];

    assign result = ovf ? (a_sign_q ? SAT_NEG : SAT_POS) : sum_raw;
`else
    assign result = sum_raw;
`endif

endmodule
